// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: funct3 width/sign codes and responder state encoding shared by
// the data-memory responder and its lane aligner.
package rv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  // Stores only have signed B/H/W encodings; loads reject the unused codes.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return we ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte/half/word lane extraction with extension for loads,
// byte-lane merge for stores, and natural-alignment check.
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wword_o,
  output logic        misalign_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask, hmask, lmask, wrep;
  always_comb begin
    b = 8'(word_i >> {off_i, 3'b000});
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
    rdata_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
              funct3_i == F3_BU ? {24'h0, b} :
              funct3_i == F3_H  ? {{16{h[15]}}, h} :
              funct3_i == F3_HU ? {16'h0, h} :
              funct3_i == F3_W  ? word_i : 32'h0;
    bmask = 32'h0000_00FF << {off_i, 3'b000};
    hmask = off_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    lmask = funct3_i == F3_B ? bmask :
            funct3_i == F3_H ? hmask :
            funct3_i == F3_W ? 32'hFFFF_FFFF : 32'h0;
    // Replicate the low lanes so the mask alone picks the destination bytes.
    wrep = funct3_i == F3_B ? {4{wdata_i[7:0]}} :
           funct3_i == F3_H ? {2{wdata_i[15:0]}} : wdata_i;
    wword_o = (word_i & ~lmask) | (wrep & lmask);
    misalign_o = ((funct3_i == F3_H || funct3_i == F3_HU) && off_i[0]) ||
                 (funct3_i == F3_W && off_i != 2'b00);
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle RV32I data-memory responder; accepts one
// request per handshake, commits after LATENCY cycles, holds the response.
module data_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam int unsigned IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic we_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic accept, commit, c_we, below, range_err, misalign, err;
  logic [2:0] c_f3;
  logic [31:0] c_addr, c_wdata, off, widx, word, ld_data, st_word;
  logic [IW-1:0] idx;
  assign accept = req_valid_i && state_q == IDLE;
  // With a single-cycle latency the commit happens on the accept edge itself,
  // so the access must use the live request rather than the latched copy.
  assign commit  = rst_ni && (LATENCY == 1 ? accept : (state_q == BUSY && cnt_q == CW'(1)));
  assign c_we    = LATENCY == 1 ? req_we_i     : we_q;
  assign c_f3    = LATENCY == 1 ? req_funct3_i : f3_q;
  assign c_addr  = LATENCY == 1 ? req_addr_i   : addr_q;
  assign c_wdata = LATENCY == 1 ? req_wdata_i  : wdata_q;
  assign {below, off} = {1'b0, c_addr} - {1'b0, ADDR_BASE};
  assign widx      = off >> 2;
  assign range_err = below || widx >= DEPTH_WORDS;
  assign idx       = range_err ? '0 : widx[IW-1:0];
  assign word      = mem_q[idx];
  assign err       = range_err || misalign || f3_illegal(c_we, c_f3);
  mem_lane_align u_align (
    .word_i    (word),
    .wdata_i   (c_wdata),
    .off_i     (c_addr[1:0]),
    .funct3_i  (c_f3),
    .rdata_o   (ld_data),
    .wword_o   (st_word),
    .misalign_o(misalign)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (commit && c_we && !err) mem_q[idx] <= st_word;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = LATENCY == 1 ? RESP : BUSY;
        cnt_d   = CW'(LATENCY - 1);
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: if (rsp_valid_q && rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The response register is raised one cycle into RESP, giving LATENCY
    // cycles from the accept edge to rsp_valid.
    rsp_valid_d = state_q == RESP && !(rsp_valid_q && rsp_ready_i);
    rdata_d     = commit ? ((c_we || err) ? 32'h0 : ld_data) : rdata_q;
    err_d       = commit ? err : err_q;
  end
  always_comb begin
    req_ready_o = state_q == IDLE;
    rsp_valid_o = rsp_valid_q;
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end
endmodule
